// File: rtl/bcd_timekeeper_pkg.sv
// Shared types, segment constants and BCD time helpers for bcd_timekeeper.
// The optional alarm (macro BCD_TIMEKEEPER_ALARM_EN) uses is_legal_time too.
package bcd_timekeeper_pkg;

    typedef logic [3:0] bcd_t;

    // Packing matches set_time/time_bcd: {h10,h1,m10,m1,s10,s1}, h10 in the MSBs.
    typedef struct packed {
        bcd_t h10;
        bcd_t h1;
        bcd_t m10;
        bcd_t m1;
        bcd_t s10;
        bcd_t s1;
    } time_t;

    typedef enum logic {
        LD_IDLE  = 1'b0,
        LD_CHECK = 1'b1
    } load_state_e;

    // Active-high segment patterns, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Decimal points lit between HH.MM.SS (digits 2 and 4), active-high form.
    localparam logic [5:0] DP_LIT = 6'b010100;

    // True when every digit is BCD, tens of minutes/seconds <= 5 and hour <= 23.
    function automatic logic is_legal_time(time_t t);
        logic hour_ok;
        hour_ok = (t.h10 <= 4'd2) && (t.h1 <= 4'd9) && !((t.h10 == 4'd2) && (t.h1 > 4'd3));
        return hour_ok && (t.m10 <= 4'd5) && (t.m1 <= 4'd9) &&
               (t.s10 <= 4'd5) && (t.s1 <= 4'd9);
    endfunction

    // One-second BCD increment with the full ripple carry and 23:59:59 wrap.
    function automatic time_t time_inc(time_t t);
        time_t n;
        n = t;
        if (t.s1 != 4'd9) begin
            n.s1 = 4'(t.s1 + 4'd1);
        end else begin
            n.s1 = 4'd0;
            if (t.s10 != 4'd5) begin
                n.s10 = 4'(t.s10 + 4'd1);
            end else begin
                n.s10 = 4'd0;
                if (t.m1 != 4'd9) begin
                    n.m1 = 4'(t.m1 + 4'd1);
                end else begin
                    n.m1 = 4'd0;
                    if (t.m10 != 4'd5) begin
                        n.m10 = 4'(t.m10 + 4'd1);
                    end else begin
                        n.m10 = 4'd0;
                        if ((t.h10 == 4'd2) && (t.h1 == 4'd3)) begin
                            n.h10 = 4'd0;
                            n.h1  = 4'd0;
                        end else if (t.h1 == 4'd9) begin
                            n.h1  = 4'd0;
                            n.h10 = 4'(t.h10 + 4'd1);
                        end else begin
                            n.h1  = 4'(t.h1 + 4'd1);
                        end
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_timekeeper_seg7_encoder.sv
// Single BCD digit to active-high 7-segment pattern, with blanking.
// Polarity is handled by the parent.
import bcd_timekeeper_pkg::*;

module seg7_encoder (
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup; blank overrides the digit.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD HH:MM:SS timekeeper with validated time load, 12/24 h display and
// 7-segment drive. Optional alarm enabled by BCD_TIMEKEEPER_ALARM_EN.
//
// Load handshake: a load is accepted on a clk edge where set_valid and
// set_ready are both 1; set_ready drops for the single CHECK cycle that
// follows, and the load (or a one-cycle set_err) takes effect at the end
// of that cycle.
import bcd_timekeeper_pkg::*;

module bcd_timekeeper #(
    parameter int CLK_HZ         = 50000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DP_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_12h,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ready,
    output logic        set_err,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic        sec_pulse,
    output logic [41:0] seg,
`ifdef BCD_TIMEKEEPER_ALARM_EN
    input  logic        alarm_set,
    input  logic        alarm_arm,
    output logic        alarm,
`endif
    output logic [5:0]  dp
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q;
    time_t         time_q;
    time_t         cap_q;
    load_state_e   state_q, state_d;
    logic          ready_q;
    logic          sec_pulse_q;
    logic          set_err_q;
    logic          tick;
    logic          accept;
    logic          load_apply;
    logic          load_reject;
    logic          alarm_reject;

    assign tick        = (presc_q == PRESC_MAX);
    assign set_ready   = ready_q && (state_q == LD_IDLE);
    assign accept      = set_ready && set_valid;
    assign load_apply  = (state_q == LD_CHECK) && is_legal_time(cap_q);
    assign load_reject = (state_q == LD_CHECK) && !is_legal_time(cap_q);

    // Load FSM state, ready flag (low through reset) and captured request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_IDLE;
            ready_q <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (accept) begin
                cap_q <= time_t'(set_time);
            end
        end
    end

    // Load FSM next state: CHECK always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE:  if (accept) state_d = LD_CHECK;
            LD_CHECK: state_d = LD_IDLE;
            default:  state_d = LD_IDLE;
        endcase
    end

    // Prescaler and time; a legal load restarts the second and swallows any tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            time_q      <= '0;
            sec_pulse_q <= 1'b0;
        end else if (load_apply) begin
            presc_q     <= '0;
            time_q      <= cap_q;
            sec_pulse_q <= 1'b0;
        end else begin
            sec_pulse_q <= tick;
            if (tick) begin
                presc_q <= '0;
                time_q  <= time_inc(time_q);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

`ifdef BCD_TIMEKEEPER_ALARM_EN
    time_t         time_next;
    logic [15:0]   alarm_hm_q;
    logic          alarm_q;
    logic          alarm_hit;
    logic          alarm_legal;

    assign time_next    = time_inc(time_q);
    assign alarm_legal  = is_legal_time(time_t'({set_time[23:8], 8'h00}));
    assign alarm_reject = alarm_set && !alarm_legal;
    assign alarm_hit    = tick && !load_apply && (time_next.s10 == 4'd0) &&
                          (time_next.s1 == 4'd0) &&
                          ({time_next.h10, time_next.h1, time_next.m10, time_next.m1} == alarm_hm_q);

    // Stored alarm time and the latched alarm flag, which arm=0 clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hm_q <= '0;
            alarm_q    <= 1'b0;
        end else begin
            if (alarm_set && alarm_legal) begin
                alarm_hm_q <= set_time[23:8];
            end
            if (!alarm_arm) begin
                alarm_q <= 1'b0;
            end else if (alarm_hit) begin
                alarm_q <= 1'b1;
            end
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm_reject = 1'b0;
`endif

    // Rejected loads produce a single-cycle error pulse after the CHECK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_err_q <= 1'b0;
        end else begin
            set_err_q <= load_reject || alarm_reject;
        end
    end

    assign set_err   = set_err_q;
    assign sec_pulse = sec_pulse_q;
    assign time_bcd  = time_q;
    assign pm        = (time_q.h10 == 4'd2) || ((time_q.h10 == 4'd1) && (time_q.h1 >= 4'd2));

    bcd_t disp_h10, disp_h1;
    logic h10_blank;

    // Hour digits for display: 12 h mode remaps 00 and 13..23 and blanks a leading zero.
    always_comb begin
        disp_h10  = time_q.h10;
        disp_h1   = time_q.h1;
        h10_blank = 1'b0;
        if (mode_12h) begin
            if ((time_q.h10 == 4'd0) && (time_q.h1 == 4'd0)) begin
                disp_h10 = 4'd1;
                disp_h1  = 4'd2;
            end else if ((time_q.h10 == 4'd1) && (time_q.h1 >= 4'd3)) begin
                disp_h10 = 4'd0;
                disp_h1  = 4'(time_q.h1 - 4'd2);
            end else if ((time_q.h10 == 4'd2) && (time_q.h1 <= 4'd1)) begin
                disp_h10 = 4'd0;
                disp_h1  = 4'(time_q.h1 + 4'd8);
            end else if (time_q.h10 == 4'd2) begin
                disp_h10 = 4'd1;
                disp_h1  = 4'(time_q.h1 - 4'd2);
            end
            h10_blank = (disp_h10 == 4'd0);
        end
    end

    bcd_t        digit_v [6];
    logic        blank_v [6];
    logic [41:0] seg_raw;

    // Digit order d0 = s1 ... d5 = h10.
    always_comb begin
        digit_v[0] = time_q.s1;
        digit_v[1] = time_q.s10;
        digit_v[2] = time_q.m1;
        digit_v[3] = time_q.m10;
        digit_v[4] = disp_h1;
        digit_v[5] = disp_h10;
        blank_v[0] = 1'b0;
        blank_v[1] = 1'b0;
        blank_v[2] = 1'b0;
        blank_v[3] = 1'b0;
        blank_v[4] = 1'b0;
        blank_v[5] = h10_blank;
    end

    for (genvar g = 0; g < 6; g++) begin : g_enc
        seg7_encoder u_enc (
            .digit (digit_v[g]),
            .blank (blank_v[g]),
            .seg   (seg_raw[7*g +: 7])
        );
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign dp  = DP_ACTIVE_LOW ? ~DP_LIT : DP_LIT;

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Parametrised successor of the board's single-purpose 24 h digital clock.
- Keeps HH:MM:SS in BCD from a prescaled system clock.
- Adds: a runtime 12/24 h display mode, a validated time-load handshake, configurable segment polarity and a 1 Hz strobe for other blocks.
- Drives six 7-segment digits plus decimal points directly to board pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency; prescaler terminal count is CLK_HZ-1.
- SEG_ACTIVE_LOW, 1, 1 = common-anode (segment on = 0); 0 = common-cathode.
- DP_ACTIVE_LOW, 1, polarity of the dp outputs, same convention as SEG_ACTIVE_LOW.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- mode_12h  in  1  0 = display 00-23; 1 = display 12,01-11 with pm flag.
- set_valid  in  1  load request.
- set_time  in  24  BCD {h10,h1,m10,m1,s10,s1}, always in 24 h format.
- set_ready  out  1  block can accept a load.
- set_err  out  1  one-cycle pulse when a load is rejected.
- time_bcd  out  24  current internal time, 24 h BCD, same packing as set_time.
- pm  out  1  1 when internal hour >= 12, independent of mode_12h.
- sec_pulse  out  1  one-cycle strobe on every seconds increment.
- seg  out  42  digit d uses seg[7d+6:7d] = {a,b,c,d,e,f,g}; d0 = s1 … d5 = h10.
- dp  out  6  dp[2] and dp[4] lit as separators; all others dark.

Behaviour:
- Reset (rst=1 at a clk edge): prescaler = 0, time = 00:00:00, sec_pulse = 0, set_err = 0, set_ready = 0. set_ready rises on the first cycle after rst deasserts.
- Prescaler: counts 0..CLK_HZ-1. At terminal count it wraps to 0 and issues a tick.
  - Exactly CLK_HZ cycles between ticks.
  - sec_pulse is asserted in the same cycle that time_bcd shows the new value (registered).
- Increment chain on tick, all BCD:
  - s1 9->0 carries into s10; s10 5->0 carries into m1.
  - m1 9->0 carries into m10; m10 5->0 carries into the hour.
  - Hour 23:59:59 -> 00:00:00. Hour is h10/h1 with h1 wrapping 9->0 below 20 and 3->0 at 23.
  - No digit ever holds a non-BCD value.
- Load FSM with states IDLE, CHECK:
  - IDLE: set_ready=1. set_valid=1 captures set_time and moves to CHECK.
  - CHECK (1 cycle): set_ready=0. Legal means each nibble <= 9, s10/m10 <= 5, hour <= 23.
    - If legal: time <= captured value, prescaler <= 0, sec_pulse suppressed for that cycle.
    - If illegal: set_err=1 for one cycle, time unchanged.
    - Either way, return to IDLE.
- Simultaneous events:
  - Tick in the CHECK cycle with a legal load: load wins and the tick is discarded.
  - Tick in the CHECK cycle with an illegal load: tick applied normally.
  - set_valid while in CHECK is ignored.
  - rst mid-CHECK aborts the load with no set_err.
- Display mapping:
  - mode_12h=0: digits show time_bcd directly.
  - mode_12h=1: hour 00 -> 12; 13..23 -> hour-12 (BCD-corrected); 01..12 unchanged.
  - Leading h10 = 0 shows blank in 12 h mode only.
  - Minutes and seconds are unchanged in both modes.
  - mode_12h is combinational into the display path; changing it has no effect on the internal time.
- Segment encode: combinational from registered digits, then polarity applied. Invalid codes cannot occur.

Optional Feature:
- Macro: BCD_TIMEKEEPER_ALARM_EN.
- When defined, adds the following ports:
  - alarm_set (in 1): on a rising clk with alarm_set=1, captures set_time[23:8] (HH:MM) as the alarm. Legality check as above; an illegal value pulses set_err.
  - alarm_arm (in 1).
  - alarm (out 1): set at the tick where time becomes HH:MM:00 while alarm_arm=1, cleared when alarm_arm=0 or on rst. Reset value of the stored alarm is 00:00.
- When not defined: ports absent, no alarm logic, all other behaviour identical.

Decomposition:
- Package bcd_timekeeper_pkg:
  - bcd_t (4-bit);
  - time_t struct {h10,h1,m10,m1,s10,s1};
  - SEG_* digit constants 0-9 plus blank in active-high form;
  - function is_legal_time.
- One sub-module, seg7_encoder (bcd_t + blank in, 7-bit active-high out), instantiated six times; polarity is applied in the parent.

Test Plan:
- CLK_HZ=10, rst for 3 cycles -> time_bcd=0x000000, set_ready=0 then 1, seg d0 = encoded '0' with polarity applied.
- Load 0x235958, run 2 ticks -> 23:59:59, then 00:00:00. sec_pulse seen exactly every 10 cycles and first 10 cycles after the CHECK cycle.
- Load 0x246000 -> set_err pulse 1 cycle, time unchanged. Load 0x125960 -> set_err.
- mode_12h=1 with time 0x000000 -> hour shows "12", pm=0. With 0x130500 -> h10 blank, h1 '1', pm=1. Toggling mode leaves time_bcd unchanged.
- Legal load issued so CHECK coincides with the prescaler terminal count -> loaded value held, no increment, next tick 10 cycles later.
- (ALARM_EN) alarm 07:00, armed, load 0x065959 -> alarm rises on the next tick. Deasserting arm clears it.
